// File: rtl/serial_adder.sv
// Bit-serial adder: a single full-adder cell plus a carry flop, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b - cin with borrow-out in cout).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned      CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_b_bit;
  logic             w_cin_load;
  logic             w_sum_bit;
  logic             w_carry_nxt;
  logic             w_cout_fin;
  logic [WIDTH-1:0] w_sum_fin;

`ifdef SERIAL_ADDER_SUB_EN
  logic r_sub;

  // Subtraction is a + ~b + ~cin; the borrow is the inverted final carry.
  assign w_b_bit    = r_b[0] ^ r_sub;
  assign w_cin_load = cin ^ sub;
  assign w_cout_fin = w_carry_nxt ^ r_sub;
`else
  assign w_b_bit    = r_b[0];
  assign w_cin_load = cin;
  assign w_cout_fin = w_carry_nxt;
`endif

  assign w_sum_bit   = r_a[0] ^ w_b_bit ^ r_carry;
  assign w_carry_nxt = (r_a[0] & w_b_bit) | (r_carry & (r_a[0] ^ w_b_bit));
  assign w_sum_fin   = {w_sum_bit, r_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sh    <= '0;
            r_carry <= w_cin_load;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= sub;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          // start is ignored here, so in-flight operands cannot be disturbed.
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sh    <= w_sum_fin;
          r_carry <= w_carry_nxt;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            sum     <= w_sum_fin;
            cout    <= w_cout_fin;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random traffic against an arithmetic model.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // {cout,sum} from plain integer arithmetic; when subtracting cout is the borrow.
  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic c, input logic s);
    longint r;
    if (s) begin
      r = longint'(x) - longint'(y) - longint'(c);
      return {(r < 0) ? 1'b1 : 1'b0, WIDTH'(r)};
    end
    r = longint'(x) + longint'(y) + longint'(c);
    return (WIDTH+1)'(r);
  endfunction

  // Model: an accepted op finishes exactly WIDTH edges later; start only counts when nothing is in flight.
  int               cyc = 0;
  int               m_fin = 0;
  logic             m_inflight = 1'b0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_cout = 1'b0;
  logic [WIDTH-1:0] p_sum = '0;
  logic             p_cout = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_inflight <= 1'b0;
      m_done     <= 1'b0;
      m_sum      <= '0;
      m_cout     <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_inflight && cyc == m_fin) begin
        m_done     <= 1'b1;
        m_sum      <= p_sum;
        m_cout     <= p_cout;
        m_inflight <= 1'b0;
      end
      if (!m_inflight && start) begin
        m_inflight      <= 1'b1;
        m_fin           <= cyc + WIDTH;
        {p_cout, p_sum} <= ref_result(a, b, cin, sub);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", 64'(busy), 64'(m_inflight));
      chk("cyc done", 64'(done), 64'(m_done));
      chk("cyc sum",  64'(sum),  64'(m_sum));
      chk("cyc cout", 64'(cout), 64'(m_cout));
    end
  end

  // Called #1 after an edge; returns #1 after the edge that raised done.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2, input logic tc,
                        input logic ts, input logic [WIDTH-1:0] es, input logic ec, input string nm);
    int n;
    int nbusy;
    bit seen;
    start = 1'b1; a = ta; b = tb2; cin = tc; sub = ts;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy@accept"}, 64'(busy), 64'd1);
    n = 0; nbusy = 1; seen = 0;
    while (!seen && n < 4 * WIDTH) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
      else if (busy) nbusy++;
    end
    chk({nm, " latency"}, 64'(n), 64'(WIDTH));
    chk({nm, " busy cycles"}, 64'(nbusy), 64'(WIDTH));
    chk({nm, " sum"}, 64'(sum), 64'(es));
    chk({nm, " cout"}, 64'(cout), 64'(ec));
  endtask

  initial begin
    int n;
    int ndone;
    logic [WIDTH-1:0] seen_sum;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset sum",  64'(sum),  64'd0);
    chk("reset cout", 64'(cout), 64'd0);
    rst = 1'b0;
    chk_en = 1;
    @(posedge clk); #1;

    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, "add5A33");
    @(posedge clk); #1;
    chk("idle holds sum", 64'(sum), 64'h8D);
    chk("done one cycle", 64'(done), 64'd0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "addFF01");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "addFFFFc");
    @(posedge clk); #1;

    // Start while busy must be ignored.
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; a = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; seen_sum = '0;
    repeat (3 * WIDTH) begin
      @(posedge clk); #1;
      if (done) begin ndone++; seen_sum = sum; end
    end
    chk("ignore start done count", 64'(ndone), 64'd1);
    chk("ignore start sum", 64'(seen_sum), 64'h30);

    // Reset after three SHIFT edges aborts the op.
    start = 1'b1; a = 8'h5A; b = 8'h33;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort sum",  64'(sum),  64'd0);
    chk("abort cout", 64'(cout), 64'd0);
    ndone = 0;
    repeat (2 * WIDTH) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, "after abort");

    // Back-to-back accept from DONE.
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, "b2b first");
    start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 4 * WIDTH) begin @(posedge clk); #1; n++; end
    chk("b2b spacing", 64'(n), 64'(WIDTH + 1));
    chk("b2b sum", 64'(sum), 64'h07);
    chk("b2b cout", 64'(cout), 64'd0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, "sub0507");
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b0, "sub0705b");
    run_op(8'h07, 8'h05, 1'b1, 1'b0, 8'h0D, 1'b0, "add after sub");
`endif

    // Random traffic, including starts while busy and occasional resets.
    repeat (3000) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      sub   = 1'($urandom_range(0, 1));
`else
      sub   = 1'b0;
`endif
      rst   = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (2 * WIDTH + 2) @(posedge clk);
    #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand and result width in bits, legal range 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The module SHALL have port a, input, WIDTH bits: first operand, sampled only when start is accepted.
REQ-006 The module SHALL have port b, input, WIDTH bits: second operand, sampled only when start is accepted.
REQ-007 The module SHALL have port cin, input, 1 bit: carry-in (borrow-in when subtracting), sampled only when start is accepted.
REQ-008 The module SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The module SHALL have port sum, output, WIDTH bits: result (sum or difference).
REQ-011 The module SHALL have port cout, output, 1 bit: carry-out (borrow-out when subtracting).

Function
REQ-012 The block SHALL compute the result one bit per clock, LSB first, through a single full-adder cell and a registered carry flip-flop.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; on acceptance, a, b and cin SHALL be loaded into shift registers and the carry flop, the bit counter SHALL clear, and the state SHALL become SHIFT.
REQ-015 In SHIFT, each edge SHALL consume the LSB of both operand registers, shift the result bit into the MSB of the sum register, update the carry flop and increment the counter.
REQ-016 After the WIDTH-th SHIFT edge, the state SHALL become DONE; done=1, busy=0, and sum and cout SHALL be valid.
REQ-017 done SHALL be high WIDTH edges after the accepting edge, for exactly one cycle.
REQ-018 From DONE, the state SHALL go to IDLE on the next edge unless start is high, in which case a new operation SHALL be accepted back-to-back.
REQ-019 busy SHALL be 1 exactly while in SHIFT.
REQ-020 start while busy SHALL be ignored, and the in-flight operands SHALL be unaffected.
REQ-021 sum and cout SHALL hold their last result in IDLE until the next completion; sum SHALL never show partial results in IDLE or DONE (a separate output register loaded at completion).
REQ-022 Results SHALL be modulo 2^WIDTH with carry in cout: {cout,sum} = a + b + cin.

Reset
REQ-023 With rst high at an edge, the next state SHALL be IDLE with busy=0, done=0, sum=0, cout=0, counter=0 and carry flop=0; rst SHALL take priority over start.
REQ-024 Reset mid-operation SHALL abort the operation, produce no done pulse, and leave no stale state affecting the next operation.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN SHALL select subtraction support.
REQ-026 With SERIAL_ADDER_SUB_EN defined, the module SHALL add input port sub, 1 bit, sampled at start acceptance; when sub=1, the block SHALL compute a - b - cin as a + ~b + ~cin, and cout SHALL be the borrow-out (inverted final carry); when sub=0, the behaviour SHALL be as in REQ-022.
REQ-027 With SERIAL_ADDER_SUB_EN undefined, port sub and all subtraction logic SHALL be absent, and the block SHALL only add.
REQ-028 Latency SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-029 The bench SHALL apply a=8'h5A, b=8'h33, cin=0, start 1 cycle -> busy for 8 cycles, done pulse 8 edges after accept, sum=8'h8D, cout=0.
REQ-030 The bench SHALL apply a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-031 The bench SHALL apply a=8'h10, b=8'h20, then, after 3 cycles, start again with a=8'hAA -> second start ignored, sum=8'h30, single done pulse.
REQ-032 The bench SHALL assert rst after 3 SHIFT cycles -> next cycle busy=0, done=0, sum=0, cout=0, no done pulse; a fresh op a=8'h01, b=8'h01 -> sum=8'h02.
REQ-033 The bench SHALL hold start high through DONE with new operands a=8'h03, b=8'h04 -> back-to-back accept, second done exactly 9 edges after the first, sum=8'h07.
REQ-034 With SERIAL_ADDER_SUB_EN defined, the bench SHALL apply sub=1, a=8'h05, b=8'h07, cin=0 -> sum=8'hFE, cout=1; then sub=1, a=8'h07, b=8'h05, cin=1 -> sum=8'h01, cout=0.
